// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with a first-word fall-through receive FIFO and sticky
// overrun / framing-error flags. The serial input is resynchronised with
// two flops before any sampling.
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          uart_s_in,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          overrun,
  output logic                          frame_err
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [15:0]      HALF_LOAD = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0]      FULL_LOAD = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0]      BAUD_ONE  = 16'd1;
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t           state;
  logic             sync1;
  logic             sync2;
  logic [15:0]      baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic             push_req;
  logic             stop_bad;
  logic             fifo_full;
  logic             fifo_empty;
  logic             do_push;
  logic             do_pop;
  logic             ovr_evt;

  // Two-flop synchroniser on the asynchronous serial line, idles high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= uart_s_in;
      sync2 <= sync1;
    end
  end

  // Frame receiver: mid-bit sampling driven by a reloading baud down-counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!sync2) begin
            state    <= START;
            bit_idx  <= '0;
            baud_cnt <= HALF_LOAD;
          end
        end
        START: begin
          if (baud_cnt == '0) begin
            if (!sync2) begin
              state    <= DATA;
              baud_cnt <= FULL_LOAD;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - BAUD_ONE;
          end
        end
        DATA: begin
          if (baud_cnt == '0) begin
            shift_reg[bit_idx] <= sync2;
            baud_cnt           <= FULL_LOAD;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - BAUD_ONE;
          end
        end
        STOP: begin
          if (baud_cnt == '0) begin
            state <= sync2 ? IDLE : WAIT_HIGH;
          end else begin
            baud_cnt <= baud_cnt - BAUD_ONE;
          end
        end
        WAIT_HIGH: begin
          if (sync2) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stop-bit outcome and FIFO push/pop arbitration
  always_comb begin
    push_req   = (state == STOP) && (baud_cnt == '0) && sync2;
    stop_bad   = (state == STOP) && (baud_cnt == '0) && !sync2;
    fifo_full  = (rx_count == CNT_FULL);
    fifo_empty = (rx_count == '0);
    do_pop     = rd_en && !fifo_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    do_push    = push_req && (!fifo_full || do_pop);
    ovr_evt    = push_req && fifo_full && !do_pop;
  end

  // FIFO storage, wrapping pointers and occupancy count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem      <= '{default: '0};
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rx_count <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= shift_reg;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   rx_count <= rx_count + CNT_ONE;
        2'b01:   rx_count <= rx_count - CNT_ONE;
        default: rx_count <= rx_count;
      endcase
    end
  end

  // Sticky error flags; a new error event takes priority over clr_err
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (ovr_evt) begin
        overrun <= 1'b1;
      end else if (clr_err) begin
        overrun <= 1'b0;
      end
      if (stop_bad) begin
        frame_err <= 1'b1;
      end else if (clr_err) begin
        frame_err <= 1'b0;
      end
    end
  end

  // First-word fall-through head and non-empty flag
  always_comb begin
    rx_data  = mem[rd_ptr];
    rx_valid = (rx_count != '0);
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo (CLKS_PER_BIT=16, FIFO_DEPTH=4).
// Stimulus queues the bytes it expects to be read back; a negedge monitor
// checks every accepted pop against the queue head.
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       uart_s_in = 1'b1;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [2:0] rx_count;
  logic       overrun;
  logic       frame_err;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q [$];
  int         cyc = 0;
  int         frame_start_cyc = 0;
  int         valid_rise_cyc = -1;
  logic       prev_valid = 1'b0;

  uart_rx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .uart_s_in(uart_s_in),
    .rd_en    (rd_en),
    .clr_err  (clr_err),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_count (rx_count),
    .overrun  (overrun),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every accepted pop with the scoreboard head
  always @(negedge clk) begin
    if (rst && rx_valid && !prev_valid) valid_rise_cyc <= cyc;
    prev_valid <= rst && rx_valid;
    if (rst && rd_en && rx_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_unexpected: got 0x%0h expected no data", rx_data);
      end else begin
        check("pop_data", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {31'h0, rx_valid}, 0);
    check({tag, "_count"}, {29'h0, rx_count}, 0);
    check({tag, "_overrun"}, {31'h0, overrun}, 0);
    check({tag, "_frame_err"}, {31'h0, frame_err}, 0);
    check({tag, "_data"}, {24'h0, rx_data}, 0);
  endtask

  // One 8N1 frame, bit edges aligned 1 ns after a rising edge. rd_en/clr_err
  // can be raised for exactly the stop-sample (push) cycle. abort_bit >= 0
  // pulses reset in the middle of that data bit and abandons the frame.
  task automatic send_frame(input logic [7:0] b, input logic stop_val,
                            input logic pop_at_push, input logic clr_at_push,
                            input int abort_bit);
    @(posedge clk);
    #1 uart_s_in = 1'b0;
    frame_start_cyc = cyc;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 uart_s_in = b[i];
      if (i == abort_bit) begin
        repeat (CPB / 2) @(posedge clk);
        #2 uart_s_in = 1'b1;
        rst = 1'b0;
        exp_q.delete();
        #1 check_reset_outputs("async_rst");
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        return;
      end
      repeat (CPB) @(posedge clk);
    end
    #1 uart_s_in = stop_val;
    repeat (10) @(posedge clk);
    #1 rd_en = pop_at_push;
    clr_err = clr_at_push;
    @(posedge clk);
    #1 rd_en = 1'b0;
    clr_err = 1'b0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic pop_one(input string name);
    int t = 0;
    while (!rx_valid && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!rx_valid) begin
      check({name, "_ready"}, {31'h0, rx_valid}, 1);
    end else begin
      rd_en = 1'b1;
      @(posedge clk);
      #1 rd_en = 1'b0;
    end
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #1 clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
  endtask

  initial begin
    logic [7:0] seq [4];
    int lat;

    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Single valid frame and its latency from the falling edge
    valid_rise_cyc = -1;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, -1);
    lat = valid_rise_cyc - frame_start_cyc;
    // 2 sync + 8 half-bit + 9*16 bit cycles to the push, plus the registered count
    check("a5_latency_ok", {31'h0, (valid_rise_cyc >= 0) && (lat <= 2 + 8 + 9 * CPB + 1)}, 1);
    check("a5_count", {29'h0, rx_count}, 1);
    check("a5_frame_err", {31'h0, frame_err}, 0);
    pop_one("a5_pop");
    check("a5_empty_after", {31'h0, rx_valid}, 0);

    // Read with FIFO empty is ignored
    rd_en = 1'b1;
    @(posedge clk);
    #1 rd_en = 1'b0;
    check("empty_rd_count", {29'h0, rx_count}, 0);

    // 4-cycle low glitch is rejected silently
    @(posedge clk);
    #1 uart_s_in = 1'b0;
    repeat (4) @(posedge clk);
    #1 uart_s_in = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("glitch_count", {29'h0, rx_count}, 0);
    check("glitch_frame_err", {31'h0, frame_err}, 0);
    check("glitch_overrun", {31'h0, overrun}, 0);

    // Push with pop on an empty FIFO: pop ignored, push accepted
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 1'b1, 1'b0, -1);
    check("empty_pushpop_count", {29'h0, rx_count}, 1);
    pop_one("c3_pop");

    // Overrun: fifth byte dropped; clr_err in the same cycle loses to the set
    seq = '{8'h01, 8'h02, 8'h03, 8'h04};
    foreach (seq[k]) begin
      exp_q.push_back(seq[k]);
      send_frame(seq[k], 1'b1, 1'b0, 1'b0, -1);
    end
    check("fill_count", {29'h0, rx_count}, 4);
    check("fill_overrun", {31'h0, overrun}, 0);
    send_frame(8'h05, 1'b1, 1'b0, 1'b1, -1);
    check("ovr_set", {31'h0, overrun}, 1);
    check("ovr_count", {29'h0, rx_count}, 4);
    pulse_clr();
    check("ovr_cleared", {31'h0, overrun}, 0);
    repeat (4) pop_one("ovr_pop");
    check("ovr_drained", {31'h0, rx_valid}, 0);

    // Framing error with the line held low, then released
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, -1);
    check("ferr_set", {31'h0, frame_err}, 1);
    check("ferr_count", {29'h0, rx_count}, 0);
    pulse_clr();
    check("ferr_cleared", {31'h0, frame_err}, 0);
    repeat (90) @(posedge clk);
    #1 uart_s_in = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("ferr_once", {31'h0, frame_err}, 0);
    check("ferr_count_after", {29'h0, rx_count}, 0);

    // Full FIFO accepts a push that coincides with a pop
    seq = '{8'h11, 8'h22, 8'h33, 8'h44};
    foreach (seq[k]) begin
      exp_q.push_back(seq[k]);
      send_frame(seq[k], 1'b1, 1'b0, 1'b0, -1);
    end
    exp_q.push_back(8'h77);
    send_frame(8'h77, 1'b1, 1'b1, 1'b0, -1);
    check("full_pushpop_count", {29'h0, rx_count}, 4);
    check("full_pushpop_overrun", {31'h0, overrun}, 0);
    repeat (4) pop_one("full_pop");
    check("full_drained", {31'h0, rx_valid}, 0);

    // Reset during bit 3 of a frame, with one byte already queued
    exp_q.push_back(8'h99);
    send_frame(8'h99, 1'b1, 1'b0, 1'b0, -1);
    check("pre_rst_count", {29'h0, rx_count}, 1);
    send_frame(8'hE7, 1'b1, 1'b0, 1'b0, 3);
    repeat (40) @(posedge clk);
    #1;
    check("post_rst_count", {29'h0, rx_count}, 0);
    check("post_rst_frame_err", {31'h0, frame_err}, 0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, -1);
    check("post_rst_5a_count", {29'h0, rx_count}, 1);
    pop_one("post_rst_pop");
    check("final_empty", {31'h0, rx_valid}, 0);

    repeat (3) @(posedge clk);
    #1 check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
